sn_seq_ctrl: RTL and testbench

- Sequencer for a bank of NUM_GEN stochastic number generators sharing one 32-bit data/write-enable bus.
- Holds a host-written table of per-generator seeds and thresholds, and loads it into the generators over the shared bus.
- Runs the generators for a programmed bitstream length and counts the 1s on the downstream stochastic result bit.
- Reports the count to the host through a valid/ack handshake.

---
 rtl/sn_seq_ctrl_if.sv | 44 ++++
 rtl/sn_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sn_seq_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sn_seq_ctrl_if.sv
// Host and generator-bank signal bundle for sn_seq_ctrl.
//
// slave  : the sequencer (receives host commands and SN_RESULT, drives status and generator bus)
// master : the host / surrounding logic (drives commands and SN_RESULT, observes outputs)
//
// Signals:
//   CFG_WE, CFG_ADDR, CFG_DATA : seed/threshold table write port
//   START, LEN, ABORT          : operation control
//   BUSY, RES_VALID, RES_COUNT : status and result
//   RES_ACK                    : host accepts result
//   GEN_DATA, GEN_SEED_WE,
//   GEN_COMP_WE, GEN_EN        : shared generator bus
//   SN_RESULT                  : stochastic result bit from downstream logic
interface sn_seq_ctrl_if #(
  parameter int unsigned NUM_GEN = 4
);
  localparam int unsigned AW = $clog2(2 * NUM_GEN);

  logic               CFG_WE;
  logic [AW-1:0]      CFG_ADDR;
  logic [31:0]        CFG_DATA;
  logic               START;
  logic [31:0]        LEN;
  logic               ABORT;
  logic               BUSY;
  logic               RES_VALID;
  logic [31:0]        RES_COUNT;
  logic               RES_ACK;
  logic [31:0]        GEN_DATA;
  logic [NUM_GEN-1:0] GEN_SEED_WE;
  logic [NUM_GEN-1:0] GEN_COMP_WE;
  logic               GEN_EN;
  logic               SN_RESULT;

  modport slave (
    input  CFG_WE, CFG_ADDR, CFG_DATA, START, LEN, ABORT, RES_ACK, SN_RESULT,
    output BUSY, RES_VALID, RES_COUNT, GEN_DATA, GEN_SEED_WE, GEN_COMP_WE, GEN_EN
  );

  modport master (
    output CFG_WE, CFG_ADDR, CFG_DATA, START, LEN, ABORT, RES_ACK, SN_RESULT,
    input  BUSY, RES_VALID, RES_COUNT, GEN_DATA, GEN_SEED_WE, GEN_COMP_WE, GEN_EN
  );
endinterface

// File: rtl/sn_seq_ctrl.sv
// Sequencer for a bank of NUM_GEN stochastic number generators.
//
// Holds a host-written table of seeds/thresholds (entry 2g = seed of gen g, 2g+1 = threshold),
// replays it onto the shared generator bus, enables the generators for LEN cycles and counts
// the 1s on SN_RESULT that line up with enabled cycles (RES_LAT cycles later). The count is
// offered to the host with RES_VALID until RES_ACK.
//
// Ports:
//   CLK : clock
//   RST : synchronous reset, active-high
//   bus : sn_seq_ctrl_if slave modport (host command/result and generator bus)
module sn_seq_ctrl #(
  parameter int unsigned NUM_GEN = 4,
  parameter int unsigned RES_LAT = 1
) (
  input logic          CLK,
  input logic          RST,
  sn_seq_ctrl_if.slave bus
);

  localparam int unsigned NUM_WORDS = 2 * NUM_GEN;
  localparam int unsigned AW        = $clog2(NUM_WORDS);
  localparam int unsigned DW        = $clog2(RES_LAT + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_e;

  state_e             state_q;
  logic [31:0]        tbl_q [NUM_WORDS];
  logic [AW-1:0]      idx_q;
  logic [31:0]        len_q;
  logic [31:0]        run_cnt_q;
  logic [DW-1:0]      drain_cnt_q;
  logic [RES_LAT-1:0] en_line_q;
  logic [31:0]        res_count_q;
  logic               res_valid_q;
  logic [31:0]        gen_data_q;
  logic [NUM_GEN-1:0] seed_we_q;
  logic [NUM_GEN-1:0] comp_we_q;
  logic               gen_en_q;

  logic [AW-1:0]      idx_nxt;
  logic               cfg_hit;
  logic [31:0]        first_word;

  function automatic logic [NUM_GEN-1:0] gen_sel(input logic [AW-1:0] k);
    return NUM_GEN'(1) << (k >> 1);
  endfunction

  always_comb begin
    idx_nxt = idx_q + AW'(1);
    cfg_hit = (state_q == StIdle) && bus.CFG_WE && (32'(bus.CFG_ADDR) < NUM_WORDS);
    // A write to entry 0 in the START cycle must already appear on the first LOAD word.
    first_word = (cfg_hit && (bus.CFG_ADDR == '0)) ? bus.CFG_DATA : tbl_q[0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      for (int i = 0; i < int'(NUM_WORDS); i++) tbl_q[i] <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      en_line_q   <= '0;
      res_count_q <= '0;
      res_valid_q <= 1'b0;
      gen_data_q  <= '0;
      seed_we_q   <= '0;
      comp_we_q   <= '0;
      gen_en_q    <= 1'b0;
    end else begin
      // EN delay line aligns each enabled cycle with its SN_RESULT sample.
      en_line_q[0] <= gen_en_q;
      for (int i = 1; i < int'(RES_LAT); i++) en_line_q[i] <= en_line_q[i-1];

      if (en_line_q[RES_LAT-1] && bus.SN_RESULT) res_count_q <= res_count_q + 32'd1;

      if (cfg_hit) tbl_q[bus.CFG_ADDR] <= bus.CFG_DATA;

      unique case (state_q)
        StIdle: begin
          if (bus.START) begin
            len_q       <= bus.LEN;
            res_count_q <= '0;
            idx_q       <= '0;
            gen_data_q  <= first_word;
            seed_we_q   <= NUM_GEN'(1);
            comp_we_q   <= '0;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          if (idx_q == LAST_IDX) begin
            gen_data_q <= '0;
            seed_we_q  <= '0;
            comp_we_q  <= '0;
            if (len_q != 32'd0) begin
              gen_en_q  <= 1'b1;
              run_cnt_q <= len_q;
              state_q   <= StRun;
            end else begin
              drain_cnt_q <= DW'(RES_LAT);
              state_q     <= StDrain;
            end
          end else begin
            idx_q      <= idx_nxt;
            gen_data_q <= tbl_q[idx_nxt];
            seed_we_q  <= idx_nxt[0] ? '0 : gen_sel(idx_nxt);
            comp_we_q  <= idx_nxt[0] ? gen_sel(idx_nxt) : '0;
          end
        end
        StRun: begin
          if (run_cnt_q == 32'd1) begin
            gen_en_q    <= 1'b0;
            drain_cnt_q <= DW'(RES_LAT);
            state_q     <= StDrain;
          end else begin
            run_cnt_q <= run_cnt_q - 32'd1;
          end
        end
        StDrain: begin
          if (drain_cnt_q == DW'(1)) begin
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            drain_cnt_q <= drain_cnt_q - DW'(1);
          end
        end
        StDone: begin
          if (bus.RES_ACK) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Abort overrides everything above; clearing the delay line keeps stale samples
      // out of the next run's count.
      if (bus.ABORT && (state_q != StIdle)) begin
        state_q     <= StIdle;
        gen_en_q    <= 1'b0;
        gen_data_q  <= '0;
        seed_we_q   <= '0;
        comp_we_q   <= '0;
        res_valid_q <= 1'b0;
        en_line_q   <= '0;
      end
    end
  end

  assign bus.BUSY        = (state_q != StIdle);
  assign bus.RES_VALID   = res_valid_q;
  assign bus.RES_COUNT   = res_count_q;
  assign bus.GEN_DATA    = gen_data_q;
  assign bus.GEN_SEED_WE = seed_we_q;
  assign bus.GEN_COMP_WE = comp_we_q;
  assign bus.GEN_EN      = gen_en_q;

endmodule

// File: tb/tb_sn_seq_ctrl.sv
// Scoreboard bench for sn_seq_ctrl: stimulus pushes expected load words and results into
// queues, an independent monitor pops and compares whenever the DUT presents them.
module tb_sn_seq_ctrl;
  localparam int unsigned NUM_GEN = 3;
  localparam int unsigned RES_LAT = 2;
  localparam int unsigned NW      = 2 * NUM_GEN;
  localparam int unsigned AW      = $clog2(NW);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sn_seq_ctrl_if #(.NUM_GEN(NUM_GEN)) bus ();

  sn_seq_ctrl #(.NUM_GEN(NUM_GEN), .RES_LAT(RES_LAT)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0]        data;
    logic [NUM_GEN-1:0] seed;
    logic [NUM_GEN-1:0] comp;
    bit                 first;
  } load_t;
  typedef struct {
    int unsigned count;
    int unsigned len;
  } res_t;
  typedef struct {
    int unsigned due;
    bit          b;
  } due_t;

  logic [31:0] tbl_m [NW];
  load_t       load_q[$];
  res_t        res_q[$];
  bit          bits_q[$];
  due_t        due_q[$];
  int unsigned cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Downstream model: each enabled cycle yields its next stimulus bit RES_LAT cycles later;
  // every other cycle carries noise that must never be counted.
  initial begin : driver
    bus.SN_RESULT = 1'b0;
    forever begin
      @(negedge CLK);
      if (due_q.size() > 0 && due_q[0].due == cyc) begin
        bus.SN_RESULT = due_q[0].b;
        void'(due_q.pop_front());
      end else begin
        bus.SN_RESULT = ($urandom_range(0, 3) != 0);
      end
      if (bus.GEN_EN === 1'b1) begin
        due_t d;
        d.due = cyc + RES_LAT;
        d.b   = (bits_q.size() > 0) ? bits_q.pop_front() : 1'b1;
        due_q.push_back(d);
      end
    end
  end

  initial begin : monitor
    int unsigned en_cnt;
    bit          prev_valid;
    logic [31:0] held;
    load_t       e;
    res_t        r;
    en_cnt     = 0;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(negedge CLK);
      if (bus.GEN_EN === 1'b1) begin
        en_cnt++;
        check("run_bus_quiet", bus.GEN_DATA | 32'(bus.GEN_SEED_WE) | 32'(bus.GEN_COMP_WE), 0);
      end
      if ((|bus.GEN_SEED_WE) || (|bus.GEN_COMP_WE)) begin
        if (load_q.size() == 0) begin
          fail("unexpected_load_word");
        end else begin
          e = load_q.pop_front();
          if (e.first) en_cnt = 0;
          check("load_data", bus.GEN_DATA, e.data);
          check("load_seed_we", 32'(bus.GEN_SEED_WE), 32'(e.seed));
          check("load_comp_we", 32'(bus.GEN_COMP_WE), 32'(e.comp));
        end
      end
      if (bus.RES_VALID === 1'b1 && !prev_valid) begin
        if (res_q.size() == 0) begin
          fail("unexpected_result");
        end else begin
          r = res_q.pop_front();
          check("res_count", bus.RES_COUNT, r.count);
          check("en_cycles", en_cnt, r.len);
          check("loads_consumed", load_q.size(), 0);
        end
        held = bus.RES_COUNT;
      end else if (bus.RES_VALID === 1'b1) begin
        check("count_held", bus.RES_COUNT, held);
      end
      prev_valid = (bus.RES_VALID === 1'b1);
    end
  end

  task automatic flush_all();
    load_q.delete();
    res_q.delete();
    bits_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(bus.BUSY), 0);
    check({tag, "_valid"}, 32'(bus.RES_VALID), 0);
    check({tag, "_count"}, bus.RES_COUNT, 0);
    check({tag, "_data"}, bus.GEN_DATA, 0);
    check({tag, "_seed_we"}, 32'(bus.GEN_SEED_WE), 0);
    check({tag, "_comp_we"}, 32'(bus.GEN_COMP_WE), 0);
    check({tag, "_en"}, 32'(bus.GEN_EN), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    flush_all();
    for (int k = 0; k < int'(NW); k++) tbl_m[k] = '0;
  endtask

  task automatic cfg_write(input int unsigned a, input logic [31:0] d, input bit idle);
    bus.CFG_WE   = 1'b1;
    bus.CFG_ADDR = AW'(a);
    bus.CFG_DATA = d;
    tick();
    bus.CFG_WE = 1'b0;
    if (idle && a < NW) tbl_m[a] = d;
  endtask

  // Mode 0: random bits, 1: alternating 0,1,..., 2: all ones. Returns to the first LOAD cycle.
  task automatic start_op(input int unsigned len, input int mode, input bit with_wr,
                          input int unsigned wr_addr, input logic [31:0] wr_data,
                          input bit with_abort, output int unsigned exp);
    res_t r;
    exp = 0;
    if (with_wr && wr_addr < NW) tbl_m[wr_addr] = wr_data;
    for (int k = 0; k < int'(NW); k++) begin
      load_t e;
      e.data = tbl_m[k];
      e.seed = '0;
      e.comp = '0;
      if (k % 2 == 0) e.seed[k / 2] = 1'b1;
      else e.comp[k / 2] = 1'b1;
      e.first = (k == 0);
      load_q.push_back(e);
    end
    for (int unsigned i = 0; i < len; i++) begin
      bit b;
      case (mode)
        1:       b = (i % 2 == 1);
        2:       b = 1'b1;
        default: b = bit'($urandom_range(0, 1));
      endcase
      bits_q.push_back(b);
      exp += 32'(b);
    end
    r.count = exp;
    r.len   = len;
    res_q.push_back(r);
    bus.START    = 1'b1;
    bus.LEN      = len;
    bus.ABORT    = with_abort;
    bus.CFG_WE   = with_wr;
    bus.CFG_ADDR = AW'(wr_addr);
    bus.CFG_DATA = wr_data;
    tick();
    bus.START  = 1'b0;
    bus.ABORT  = 1'b0;
    bus.CFG_WE = 1'b0;
    check("busy_after_start", 32'(bus.BUSY), 1);
  endtask

  task automatic finish_op(input int unsigned exp, input int unsigned len, input int ack_delay);
    int unsigned n;
    n = 0;
    while (bus.RES_VALID !== 1'b1 && n < 2 * NW + len + RES_LAT + 20) begin
      tick();
      n++;
    end
    if (bus.RES_VALID !== 1'b1) begin
      fail("result_timeout");
      do_reset();
      return;
    end
    repeat (ack_delay) tick();
    check("valid_until_ack", 32'(bus.RES_VALID), 1);
    bus.RES_ACK = 1'b1;
    tick();
    bus.RES_ACK = 1'b0;
    check("valid_after_ack", 32'(bus.RES_VALID), 0);
    check("busy_after_ack", 32'(bus.BUSY), 0);
    check("count_after_ack", bus.RES_COUNT, exp);
  endtask

  task automatic abort_now();
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    check("abort_en", 32'(bus.GEN_EN), 0);
    check("abort_busy", 32'(bus.BUSY), 0);
    check("abort_valid", 32'(bus.RES_VALID), 0);
    check("abort_we", 32'(bus.GEN_SEED_WE) | 32'(bus.GEN_COMP_WE), 0);
    flush_all();
  endtask

  task automatic wait_en(output int unsigned n);
    n = 1;
    while (bus.GEN_EN !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned exp;
    int unsigned n;
    int unsigned m;
    bus.CFG_WE   = 1'b0;
    bus.CFG_ADDR = '0;
    bus.CFG_DATA = '0;
    bus.START    = 1'b0;
    bus.LEN      = '0;
    bus.ABORT    = 1'b0;
    bus.RES_ACK  = 1'b0;
    for (int k = 0; k < int'(NW); k++) tbl_m[k] = '0;
    RST = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    RST = 1'b0;
    tick();

    // Table fill; addresses past the table end must not alias.
    for (int unsigned k = 0; k < NW; k++) cfg_write(k, $urandom, 1'b1);
    cfg_write(6, 32'hDEAD_0006, 1'b1);
    cfg_write(7, 32'hDEAD_0007, 1'b1);

    // LEN=4 with latency checks.
    start_op(4, 2, 1'b0, 0, '0, 1'b0, exp);
    wait_en(n);
    check("start_to_en", n, 2 * NUM_GEN + 1);
    m = 0;
    while (bus.GEN_EN === 1'b1 && m < 200) begin
      tick();
      m++;
    end
    check("en_width", m, 4);
    m = 1;
    while (bus.RES_VALID !== 1'b1 && m < 100) begin
      tick();
      m++;
    end
    check("en_to_valid", m, RES_LAT + 1);
    finish_op(exp, 4, 2);

    // LEN=100 alternating samples.
    start_op(100, 1, 1'b0, 0, '0, 1'b0, exp);
    finish_op(exp, 100, 3);

    // LEN=0: no enable, LOAD then DRAIN only.
    start_op(0, 0, 1'b0, 0, '0, 1'b0, exp);
    n = 1;
    while (bus.RES_VALID !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("len0_latency", n, 2 * NUM_GEN + RES_LAT + 1);
    finish_op(exp, 0, 0);

    // Abort in the 10th RUN cycle, then a clean LEN=8 run of ones.
    start_op(30, 2, 1'b0, 0, '0, 1'b0, exp);
    wait_en(n);
    repeat (9) tick();
    abort_now();
    repeat (6) tick();
    check("no_valid_after_abort", 32'(bus.RES_VALID), 0);
    start_op(8, 2, 1'b0, 0, '0, 1'b0, exp);
    finish_op(exp, 8, 1);

    // START and CFG_WE during RUN are ignored; the next LOAD replays the old table.
    start_op(20, 0, 1'b0, 0, '0, 1'b0, exp);
    wait_en(n);
    tick();
    cfg_write(0, 32'hA5A5_0000, 1'b0);
    cfg_write(3, 32'hA5A5_0003, 1'b0);
    bus.START = 1'b1;
    bus.LEN   = 5;
    tick();
    bus.START = 1'b0;
    finish_op(exp, 20, 0);
    start_op(3, 0, 1'b0, 0, '0, 1'b0, exp);
    finish_op(exp, 3, 0);

    // CFG_WE together with START: the new value is loaded.
    start_op(5, 0, 1'b1, 0, $urandom, 1'b0, exp);
    finish_op(exp, 5, 0);
    start_op(2, 0, 1'b1, NW - 1, $urandom, 1'b0, exp);
    finish_op(exp, 2, 1);

    // START together with ABORT in IDLE: START wins.
    start_op(6, 0, 1'b0, 0, '0, 1'b1, exp);
    finish_op(exp, 6, 0);

    // Reset in the middle of LOAD.
    start_op(5, 2, 1'b0, 0, '0, 1'b0, exp);
    tick();
    tick();
    RST = 1'b1;
    tick();
    check_reset_vals("midload_rst");
    RST = 1'b0;
    flush_all();
    for (int k = 0; k < int'(NW); k++) tbl_m[k] = '0;
    tick();
    start_op(3, 2, 1'b0, 0, '0, 1'b0, exp);
    finish_op(exp, 3, 0);

    // Randomized operations with occasional aborts.
    for (int it = 0; it < 20; it++) begin
      int unsigned len;
      int unsigned nwr;
      bit          ab;
      nwr = $urandom_range(0, 3);
      for (int w = 0; w < int'(nwr); w++) cfg_write($urandom_range(0, 7), $urandom, 1'b1);
      len = $urandom_range(0, 40);
      ab  = ($urandom_range(0, 3) == 0);
      start_op(len, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)),
               $urandom_range(0, 7), $urandom, 1'b0, exp);
      if (ab) begin
        repeat ($urandom_range(0, 2 * NUM_GEN + len - 1)) tick();
        abort_now();
        tick();
      end else begin
        finish_op(exp, len, int'($urandom_range(0, 3)));
      end
    end

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
